mod_msg_schedule: RTL and testbench



---
 rtl/mod_msg_schedule_pkg.sv | 16 +
 rtl/mod_sigma0.sv | 7 +
 rtl/mod_sigma1.sv | 7 +
 rtl/mod_msg_schedule.sv | 104 ++++++++++
 tb/tb_mod_msg_schedule.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/mod_msg_schedule_pkg.sv
// Shared SHA-256 stage constants for the message-schedule expander.
package mod_msg_schedule_pkg;

   localparam int WORD_W = 32;
   localparam int N_IN   = 16;
   localparam int N_OUT  = 64;

   localparam logic ST_LOAD = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   // Circular-buffer offsets from slot t%16 to W[t-2], W[t-7], W[t-15].
   localparam logic [3:0] OFF_M2  = 4'd14;
   localparam logic [3:0] OFF_M7  = 4'd9;
   localparam logic [3:0] OFF_M15 = 4'd1;

endpackage

// File: rtl/mod_sigma0.sv
// SHA-256 small sigma0: ROTR7 ^ ROTR18 ^ SHR3.
module mod_sigma0 (
   input  logic [31:0] x,
   output logic [31:0] y
);
   assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
endmodule

// File: rtl/mod_sigma1.sv
// SHA-256 small sigma1: ROTR17 ^ ROTR19 ^ SHR10.
module mod_sigma1 (
   input  logic [31:0] x,
   output logic [31:0] y
);
   assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
endmodule

// File: rtl/mod_msg_schedule.sv
// SHA-256 message-schedule expander: loads W0..W15, streams W0..W63 out of a
// 16-word circular buffer, overwriting slot t%16 with each new W[t].
module mod_msg_schedule
   import mod_msg_schedule_pkg::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [0:31] IN_W,
   input  logic        IN_VALID,
   output logic        IN_READY,
   output logic [0:31] OUT_W,
   output logic [0:5]  OUT_T,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic        OUT_LAST
);

   logic              state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [5:0]        t_q, t_d;
   logic              rdy_q;
   logic [WORD_W-1:0] wbuf_q [N_IN];

   logic              wr_en;
   logic [3:0]        wr_idx;
   logic [WORD_W-1:0] wr_data;
   logic [3:0]        i0, im2, im7, im15;
   logic [WORD_W-1:0] sig0, sig1, sched_w;
   logic              in_ready, in_fire, out_valid, out_fire;

   assign i0   = t_q[3:0];
   assign im2  = i0 + OFF_M2;
   assign im7  = i0 + OFF_M7;
   assign im15 = i0 + OFF_M15;

   mod_sigma0 u_sigma0 (.x(wbuf_q[im15]), .y(sig0));
   mod_sigma1 u_sigma1 (.x(wbuf_q[im2]),  .y(sig1));

   always_comb begin
      sched_w = wbuf_q[i0];
      if (t_q >= 6'(N_IN))
         sched_w = sig1 + wbuf_q[im7] + sig0 + wbuf_q[i0];
   end

   assign in_ready  = rdy_q & (state_q == ST_LOAD);
   assign in_fire   = IN_VALID & in_ready;
   assign out_valid = (state_q == ST_RUN);
   assign out_fire  = out_valid & OUT_READY;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      t_d     = t_q;
      wr_en   = 1'b0;
      wr_idx  = cnt_q;
      wr_data = IN_W;
      if (state_q == ST_LOAD) begin
         if (in_fire) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(N_IN - 1)) begin
               state_d = ST_RUN;
               t_d     = 6'd0;
            end
         end
      end else if (out_fire) begin
         // First 16 words come straight from the load; later ones replace W[t-16].
         wr_en   = (t_q >= 6'(N_IN));
         wr_idx  = i0;
         wr_data = sched_w;
         t_d     = t_q + 6'd1;
         if (t_q == 6'(N_OUT - 1)) begin
            state_d = ST_LOAD;
            cnt_d   = 4'd0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_LOAD;
         cnt_q   <= 4'd0;
         t_q     <= 6'd0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         t_q     <= t_d;
         rdy_q   <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en)
         wbuf_q[wr_idx] <= wr_data;
   end

   assign IN_READY  = in_ready;
   assign OUT_VALID = out_valid;
   assign OUT_W     = out_valid ? sched_w : '0;
   assign OUT_T     = out_valid ? t_q : '0;
   assign OUT_LAST  = out_valid & (t_q == 6'(N_OUT - 1));

endmodule

// File: tb/tb_mod_msg_schedule.sv
// Directed bench for the SHA-256 schedule expander against a reference recurrence.
module tb_mod_msg_schedule;

   typedef logic [31:0] blk_t   [16];
   typedef logic [31:0] sched_t [64];

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [0:31] IN_W;
   logic        IN_VALID;
   logic        IN_READY;
   logic [0:31] OUT_W;
   logic [0:5]  OUT_T;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic        OUT_LAST;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] got [64];

   mod_msg_schedule dut (
      .CLK(CLK), .RST_N(RST_N),
      .IN_W(IN_W), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .OUT_W(OUT_W), .OUT_T(OUT_T), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ss0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ss1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   task automatic model(input blk_t b, output sched_t s);
      for (int i = 0; i < 16; i++) s[i] = b[i];
      for (int i = 16; i < 64; i++) s[i] = ss1(s[i-2]) + s[i-7] + ss0(s[i-15]) + s[i-16];
   endtask

   // Called at posedge+1; returns at posedge+1 after the 16th accepted word.
   task automatic load_block(input blk_t b, input bit gaps);
      int i = 0;
      int guard = 0;
      bit hs;
      while (i < 16 && guard < 400) begin
         guard++;
         IN_VALID = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         IN_W     = IN_VALID ? b[i] : 32'hDEADBEEF;
         @(negedge CLK);
         hs = IN_VALID & IN_READY;
         @(posedge CLK); #1;
         if (hs) i++;
      end
      IN_VALID = 1'b0;
      if (i < 16) chk("load_timeout", i, 16);
   endtask

   // mode 0: ready held high, 1: random ready with 10-cycle stall at t=16.
   task automatic drain(input sched_t exp, input int mode, input bit hold_in, input int stop_t);
      int t = 0;
      int guard = 0;
      int stall = 0;
      bit rdy;
      while (t < stop_t && guard < 2000) begin
         guard++;
         rdy = 1'b1;
         if (mode == 1) begin
            if (t == 16 && stall < 10) begin rdy = 1'b0; stall++; end
            else rdy = ($urandom_range(0, 2) != 0);
         end
         OUT_READY = rdy;
         if (hold_in) begin IN_VALID = 1'b1; IN_W = 32'hCAFEF00D; end
         @(negedge CLK);
         chk("out_valid", OUT_VALID, 1);
         chk("out_w", OUT_W, exp[t]);
         chk("out_t", 32'(OUT_T), 32'(t));
         chk("out_last", OUT_LAST, (t == 63));
         if (hold_in) chk("in_ready_run", IN_READY, 0);
         if (rdy) begin got[t] = OUT_W; t++; end
         @(posedge CLK); #1;
      end
      if (t < stop_t) chk("drain_timeout", t, stop_t);
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      if (stop_t == 64) begin
         @(negedge CLK);
         chk("in_ready_after", IN_READY, 1);
         chk("valid_after", OUT_VALID, 0);
         @(posedge CLK); #1;
      end
   endtask

   blk_t   abc, zero, blk_b, blk_c;
   sched_t s_abc, s_zero, s_b, s_c;

   initial begin
      for (int i = 0; i < 16; i++) begin
         abc[i]   = 32'h0;
         zero[i]  = 32'h0;
         blk_b[i] = (32'h01010101 * (i + 1)) ^ 32'hA5A55A5A;
         blk_c[i] = 32'h80000001 + 32'h12345678 * i;
      end
      abc[0]  = 32'h61626380;
      abc[15] = 32'h00000018;
      model(abc, s_abc);
      model(zero, s_zero);
      model(blk_b, s_b);
      model(blk_c, s_c);

      RST_N = 1'b0; IN_VALID = 1'b0; IN_W = '0; OUT_READY = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_in_ready", IN_READY, 0);
      chk("rst_out_valid", OUT_VALID, 0);
      chk("rst_out_w", OUT_W, 0);
      chk("rst_out_t", 32'(OUT_T), 0);
      chk("rst_out_last", OUT_LAST, 0);
      RST_N = 1'b1;
      @(posedge CLK); #1;
      chk("rel_in_ready", IN_READY, 1);

      // "abc" block, unstalled
      load_block(abc, 1'b0);
      drain(s_abc, 0, 1'b0, 64);
      chk("abc_w16", got[16], 32'h61626380);
      chk("abc_w17", got[17], 32'h000F0000);
      chk("abc_w18", got[18], 32'h7DA86405);
      chk("abc_w19", got[19], 32'h600003C6);

      // All-zero block
      load_block(zero, 1'b0);
      drain(s_zero, 0, 1'b0, 64);

      // Backpressure
      load_block(abc, 1'b0);
      drain(s_abc, 1, 1'b0, 64);
      chk("bp_w19", got[19], 32'h600003C6);

      // Input gaps during load, IN_VALID held during run, then a fresh block
      load_block(blk_b, 1'b1);
      drain(s_b, 0, 1'b1, 64);
      load_block(blk_c, 1'b0);
      drain(s_c, 0, 1'b0, 64);

      // Reset mid-block at t=30, asserted between edges
      load_block(blk_b, 1'b0);
      drain(s_b, 0, 1'b0, 30);
      #2 RST_N = 1'b0;
      #1;
      chk("mid_rst_valid", OUT_VALID, 0);
      chk("mid_rst_in_ready", IN_READY, 0);
      chk("mid_rst_out_w", OUT_W, 0);
      @(posedge CLK); #1;
      chk("mid_rst_hold_ready", IN_READY, 0);
      @(posedge CLK); #2;
      RST_N = 1'b1;
      @(posedge CLK); #1;
      chk("mid_rel_ready", IN_READY, 1);
      load_block(abc, 1'b0);
      drain(s_abc, 0, 1'b0, 64);
      chk("post_rst_w16", got[16], 32'h61626380);

      // Back-to-back distinct blocks
      load_block(blk_c, 1'b0);
      drain(s_c, 0, 1'b0, 64);
      load_block(blk_b, 1'b0);
      drain(s_b, 0, 1'b0, 64);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
